// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with write-to-read bypass and a
// hardware clear sequencer that zeroes the array after reset or on request.
module regfile_mp #(
    parameter  int XLEN   = 32,
    parameter  int NREGS  = 32,
    parameter  int NRD    = 2,
    parameter  int BYPASS = 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                 I_clk,
    input  logic                 I_rst_n,
    input  logic                 I_clear,
    input  logic                 I_re,
    input  logic [NRD*AW-1:0]    I_rs,
    input  logic                 I_we,
    input  logic [AW-1:0]        I_rd,
    input  logic [XLEN-1:0]      I_data,
    output logic [NRD*XLEN-1:0]  O_regval,
    output logic                 O_busy,
    output logic [NREGS-1:0]     O_zero_flags
);

    typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

    localparam logic [AW-1:0] CNT_FIRST = AW'(1);
    localparam logic [AW-1:0] CNT_LAST  = AW'(NREGS - 1);

    state_t              state_q, state_d;
    logic [AW-1:0]       cnt_q, cnt_d;
    logic                arr_we;
    logic [AW-1:0]       arr_idx;
    logic [XLEN-1:0]     arr_wdata;
    logic                rd_en;
    logic [NRD*XLEN-1:0] rdata;

    // Entry 0 is never written or read; x0 is synthesised as constant zero.
    logic [XLEN-1:0]     mem [NREGS];

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q <= ST_CLEAR;
            cnt_q   <= CNT_FIRST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        arr_we    = 1'b0;
        arr_idx   = cnt_q;
        arr_wdata = '0;
        rd_en     = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                arr_we = 1'b1;
                cnt_d  = cnt_q + CNT_FIRST;
                if (I_clear) begin
                    cnt_d = CNT_FIRST;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // A clear request in RUN drops any read or write in the same cycle.
                if (I_clear) begin
                    state_d = ST_CLEAR;
                    cnt_d   = CNT_FIRST;
                end else begin
                    arr_we    = I_we && (I_rd != '0);
                    arr_idx   = I_rd;
                    arr_wdata = I_data;
                    rd_en     = I_re;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (arr_we) begin
            mem[arr_idx] <= arr_wdata;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] rs_k;
        assign rs_k = I_rs[k*AW +: AW];
        assign rdata[k*XLEN +: XLEN] =
            (rs_k == '0)                                  ? '0     :
            ((BYPASS != 0) && I_we && (I_rd == rs_k))     ? I_data :
                                                            mem[rs_k];
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_regval <= '0;
        end else if (rd_en) begin
            O_regval <= rdata;
        end
    end

    assign O_busy = (state_q == ST_CLEAR);

    for (genvar i = 0; i < NREGS; i++) begin : g_zf
        if (i == 0) begin : g_x0
            assign O_zero_flags[i] = 1'b1;
        end else begin : g_xn
            assign O_zero_flags[i] = O_busy || (mem[i] == '0);
        end
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port integer register file for the CPU core. It is the successor to the two-port 32×32 file, generalised in register width, register count and read-port count. It adds a write-to-read bypass, a hardware clear sequencer that zeroes the array after reset or on request, and a busy handshake towards the pipeline. It sits between decode (read indices), writeback (write port) and the pipeline control unit, which stalls while `O_busy` is high.

## Interface
Parameters:
- `XLEN`, 32: register width in bits.
- `NREGS`, 32: number of registers; power of two, ≥ 2. `AW = $clog2(NREGS)`.
- `NRD`, 2: number of read ports, 1..4.
- `BYPASS`, 1: 1 forwards same-cycle write data to matching reads; 0 returns the old value.

Ports:
- `I_clk`  in  1  clock; all state changes on the rising edge.
- `I_rst_n`  in  1  reset, asynchronous and active-low.
- `I_clear`  in  1  synchronous request to re-zero the whole array.
- `I_re`  in  1  read enable for all ports.
- `I_rs`  in  NRD*AW  read indices; port k is bits [k*AW +: AW].
- `I_we`  in  1  write enable.
- `I_rd`  in  AW  write index.
- `I_data`  in  XLEN  write data.
- `O_regval`  out  NRD*XLEN  registered read data; port k is bits [k*XLEN +: XLEN].
- `O_busy`  out  1  high while the clear sequencer runs; reads and writes are ignored.
- `O_zero_flags`  out  NREGS  bit i is high when register i equals 0.

## Operation
- Storage: `NREGS`×`XLEN` array without reset.
  - Register 0 is hardwired to zero. Writes to index 0 are discarded, and reads of index 0 return 0.
- The FSM has two states, CLEAR and RUN, plus a clear counter `cnt` of `AW` bits.
- **Async reset:**
  - state goes to CLEAR and `cnt` to 1.
  - `O_busy` = 1.
  - `O_regval` = all zeros.
- **CLEAR:** each edge writes 0 to `reg[cnt]` and increments `cnt`.
  - On the edge that writes `reg[NREGS-1]`, the state goes to RUN and `O_busy` goes to 0.
  - `I_we` and `I_re` are ignored, and `O_regval` holds its value.
  - `I_clear` in CLEAR restarts `cnt` at 1.
- **RUN:**
  - Write: when `I_we` is high and `I_rd` ≠ 0, the next edge stores `I_data` into `reg[I_rd]`.
  - Read: when `I_re` is high, each port k captures `reg[I_rs[k]]` on the next edge. Otherwise `O_regval` holds.
  - Bypass: when `BYPASS` = 1 and a port index equals `I_rd` (≠ 0) while `I_we` is high in the same cycle, that port captures `I_data`. With `BYPASS` = 0 it captures the pre-write value.
  - `I_clear` high: on the next edge the state goes to CLEAR, `cnt` to 1 and `O_busy` to 1.
    - A write or read presented in that same cycle is dropped.
    - `O_regval` holds.
- `O_zero_flags`: combinational.
  - Bit 0 is always 1.
  - While `O_busy` is high, all bits are forced to 1.
  - In RUN, bit i = (`reg[i]` == 0).

## Timing
- Read latency is 1 cycle: the indices presented at edge N produce `O_regval` valid after edge N.
- Write-to-read without bypass:
  - A read issued one cycle after the write sees the new value.
  - With `BYPASS` = 1, a read in the same cycle as the write also sees it.
- Clear duration is `NREGS-1` edges after `I_rst_n` rises, or after the edge that samples `I_clear`.
  - With the defaults, `O_busy` falls at the 31st edge.
  - The first accepted operation is sampled at the 32nd edge.
- Reset asserted mid-CLEAR or mid-RUN takes effect immediately:
  - outputs return to their reset values;
  - the clear restarts from `cnt` = 1 after `I_rst_n` is released.
- `O_zero_flags` updates in the same cycle as the array write, after the edge.
- Simultaneous `I_clear` and `I_we` or `I_re`: clear wins.
- Multiple read ports may use the same index; all of them return the same value.

## Test plan
- **Reset and clear:**
  - Assert `I_rst_n` = 0, then release.
  - Required: `O_busy` = 1 for exactly 31 edges.
  - Required: `O_regval` = 0 throughout and `O_zero_flags` = 0xFFFFFFFF.
  - Then write `reg[5]` = 0xDEADBEEF and read it: `O_regval` port 0 = 0xDEADBEEF and `O_zero_flags[5]` = 0.
- **x0:**
  - Write 0x12345678 to index 0, then read index 0 on both ports.
  - Required: both return 0 and `O_zero_flags[0]` = 1.
- **Bypass:**
  - Same-cycle write 0xA5A5A5A5 to `reg[7]` with port 0 and port 1 both reading 7.
  - Required with `BYPASS` = 1: both ports return 0xA5A5A5A5.
  - Required with `BYPASS` = 0: both ports return the old value 0x0.
- **Hold:**
  - Read `reg[3]` = 0x11, then hold `I_re` = 0 while writing `reg[3]` = 0x22.
  - Required: `O_regval` port 0 stays 0x11 until the next read, which returns 0x22.
- **Clear request:**
  - Fill `reg[1..31]` with nonzero values, then pulse `I_clear` together with `I_we` to `reg[4]`.
  - Required: `O_busy` is high for 31 edges and the write is dropped.
  - Required afterwards: all reads return 0 and `O_zero_flags` = all ones.
- **Parameter sweep:**
  - `XLEN` = 64, `NREGS` = 16, `NRD` = 3 with random reads and writes.
  - Required: matches the reference model.
  - Required: clear lasts 15 edges.
